// File: rtl/gift_mask_pkg.sv
// gift_mask_pkg: shared sizes, FSM state type and GIFT S-box reference for the masked S-box layer
package gift_mask_pkg;
    localparam int NIBBLES = 16;
    localparam int IDX_W = $clog2(NIBBLES);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [63:0] GIFT_SBOX_REF = 64'h1a4c6f392db7508e;
endpackage

// File: rtl/gift_rnd_sched.sv
// gift_rnd_sched: splits each random byte between the issue cycle (high nibble) and the capture cycle (low nibble)
module gift_rnd_sched
    import gift_mask_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic       cap_v,
    input  logic [7:0] rnd,
    output logic [7:0] sb_r
);
    logic [3:0] lo_hold;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lo_hold <= '0;
        else if (issue) lo_hold <= rnd[3:0];
    end
    // Unused halves are driven to zero so no stale randomness reaches the core
    assign sb_r = {issue ? rnd[7:4] : 4'h0, cap_v ? lo_hold : 4'h0};
endmodule

// File: rtl/gift_sbox_layer_ctrl.sv
// gift_sbox_layer_ctrl: serialises a 3-share 64-bit state through one external 1-cycle masked S-box core
module gift_sbox_layer_ctrl
    import gift_mask_pkg::*;
#(
    parameter int NIBBLES = gift_mask_pkg::NIBBLES,
    parameter int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    input  logic [W-1:0] in_s1,
    input  logic [W-1:0] in_s2,
    input  logic [W-1:0] in_s3,
    output logic [W-1:0] out_s1,
    output logic [W-1:0] out_s2,
    output logic [W-1:0] out_s3,
    input  logic [7:0]   rnd,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    output logic [3:0]   sb_in1,
    output logic [3:0]   sb_in2,
    output logic [3:0]   sb_in3,
    output logic [7:0]   sb_r,
    input  logic [3:0]   sb_out1,
    input  logic [3:0]   sb_out2,
    input  logic [3:0]   sb_out3
);
    localparam int IW = $clog2(NIBBLES);
    state_t state;
    logic [IW-1:0] iss_idx, cap_idx;
    logic cap_v, issue;
    logic [W-1:0] s1, s2, s3;
    assign issue = (state == RUN) && rnd_valid;
    assign busy = (state == RUN) || (state == DRAIN);
    assign done = state == DONE;
    assign rnd_ready = state == RUN;
    // Share data only reaches the core on an issue cycle
    assign sb_in1 = issue ? s1[{iss_idx, 2'b00} +: 4] : 4'h0;
    assign sb_in2 = issue ? s2[{iss_idx, 2'b00} +: 4] : 4'h0;
    assign sb_in3 = issue ? s3[{iss_idx, 2'b00} +: 4] : 4'h0;
    gift_rnd_sched u_sched (
        .clk(clk),
        .rst_n(rst_n),
        .issue(issue),
        .cap_v(cap_v),
        .rnd(rnd),
        .sb_r(sb_r)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            iss_idx <= '0;
            cap_idx <= '0;
            cap_v <= 1'b0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            out_s1 <= '0;
            out_s2 <= '0;
            out_s3 <= '0;
        end else begin
            cap_v <= issue;
            cap_idx <= iss_idx;
            if (cap_v) begin
                out_s1[{cap_idx, 2'b00} +: 4] <= sb_out1;
                out_s2[{cap_idx, 2'b00} +: 4] <= sb_out2;
                out_s3[{cap_idx, 2'b00} +: 4] <= sb_out3;
            end
            case (state)
                IDLE: if (start) begin
                    s1 <= in_s1;
                    s2 <= in_s2;
                    s3 <= in_s3;
                    iss_idx <= '0;
                    state <= RUN;
                end
                RUN: if (rnd_valid) begin
                    if (iss_idx == IW'(NIBBLES - 1)) state <= DRAIN;
                    else iss_idx <= iss_idx + 1'b1;
                end
                DRAIN: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
